// File: rtl/rx_decim_pkg.sv
// Shared definitions for the Rx decimating sampler: mode encodings, accumulator
// sizing and the legacy speed-code table used by the register-map glue.
package rx_decim_pkg;

  typedef enum logic {
    MODE_PICK = 1'b0,
    MODE_SUM  = 1'b1
  } mode_e;

  // Sum of up to 2^dec_w samples needs dec_w growth bits.
  function automatic int acc_width(input int in_w, input int dec_w);
    return in_w + dec_w;
  endfunction

  function automatic logic [3:0] speed_to_dec_m1(input logic [2:0] code);
    case (code)
      3'b000:  return 4'd9;
      3'b001:  return 4'd4;
      3'b010:  return 4'd3;
      3'b011:  return 4'd1;
      3'b100:  return 4'd4;
      3'b101:  return 4'd2;
      3'b110:  return 4'd1;
      3'b111:  return 4'd0;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/rx_decim_sampler_round_sat.sv
// Combinational round-half-up by a runtime right shift, then saturation to a
// narrower signed width with a clip flag.
module rx_round_sat #(
  parameter int IN_W  = 27,
  parameter int OUT_W = 17,
  parameter int SH_W  = 5
) (
  input  logic signed [IN_W-1:0]  sample,
  input  logic        [SH_W-1:0]  shift,
  output logic signed [OUT_W-1:0] result,
  output logic                    clip
);

  localparam int EXT_W = IN_W + 1;
  localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_V = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [EXT_W-1:0] rnd_s;
  logic signed [EXT_W-1:0] sum_s;
  logic signed [EXT_W-1:0] shr_s;

  // One extra bit keeps the rounding add from wrapping at full-scale input.
  always_comb begin
    rnd_s = {EXT_W{1'b0}};
    if (shift == {SH_W{1'b0}}) begin
      rnd_s = {EXT_W{1'b0}};
    end else begin
      rnd_s = EXT_W'(1) << (shift - SH_W'(1));
    end
    sum_s = {sample[IN_W-1], sample} + rnd_s;
    shr_s = sum_s >>> shift;
  end

  // Clamp into the output range and flag any clipping.
  always_comb begin
    result = shr_s[OUT_W-1:0];
    clip   = 1'b0;
    if (shr_s > MAX_V) begin
      result = MAX_V[OUT_W-1:0];
      clip   = 1'b1;
    end else if (shr_s < MIN_V) begin
      result = MIN_V[OUT_W-1:0];
      clip   = 1'b1;
    end else begin
      result = shr_s[OUT_W-1:0];
      clip   = 1'b0;
    end
  end

endmodule

// File: rtl/rx_decim_sampler.sv
// Multi-channel pick / integrate-and-dump decimator with round-half-up and
// saturation from IN_W down to OUT_W. Capture stage, then registered output stage.
module rx_decim_sampler
  import rx_decim_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int IN_W  = 23,
  parameter int OUT_W = 17,
  parameter int DEC_W = 4,
  parameter int SH_W  = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   clr_i,
  input  logic                   mode_i,
  input  logic [DEC_W-1:0]       dec_m1_i,
  input  logic [SH_W-1:0]        shift_i,
  input  logic                   in_valid_i,
  input  logic [NCH*IN_W-1:0]    data_i,
  output logic                   valid_o,
  output logic [NCH*OUT_W-1:0]   data_o,
  output logic                   sat_o
);

  localparam int ACC_W = acc_width(IN_W, DEC_W);
  localparam int TSH_W = $clog2(IN_W - OUT_W + (1 << SH_W)) + 1;
  localparam logic [TSH_W-1:0] BASE_SH = TSH_W'(IN_W - OUT_W);

  logic [DEC_W-1:0]        cnt_r;
  mode_e                   mode_r;
  logic [DEC_W-1:0]        dec_m1_r;
  logic [SH_W-1:0]         shift_r;
  logic signed [ACC_W-1:0] acc_r [NCH];
  logic signed [ACC_W-1:0] cap_r [NCH];
  logic                    cap_valid_r;
  logic [TSH_W-1:0]        cap_sh_r;

  logic                    first_s;
  logic                    last_s;
  mode_e                   eff_mode_s;
  logic [DEC_W-1:0]        eff_dec_s;
  logic [SH_W-1:0]         eff_shift_s;
  logic [TSH_W-1:0]        frame_sh_s;
  logic signed [ACC_W-1:0] samp_s    [NCH];
  logic signed [ACC_W-1:0] nxt_acc_s [NCH];
  logic signed [ACC_W-1:0] cap_in_s  [NCH];

  logic signed [OUT_W-1:0] res_s [NCH];
  logic [NCH-1:0]          clip_s;
  logic [NCH*OUT_W-1:0]    data_pack_s;

  // The first sample of a frame sees the live config; later ones see the shadow copy.
  always_comb begin
    first_s = (cnt_r == {DEC_W{1'b0}});
    if (first_s) begin
      eff_mode_s  = mode_e'(mode_i);
      eff_dec_s   = dec_m1_i;
      eff_shift_s = shift_i;
    end else begin
      eff_mode_s  = mode_r;
      eff_dec_s   = dec_m1_r;
      eff_shift_s = shift_r;
    end
    last_s = (cnt_r == eff_dec_s);
    if (eff_mode_s == MODE_SUM) begin
      frame_sh_s = BASE_SH + TSH_W'(eff_shift_s);
    end else begin
      frame_sh_s = BASE_SH;
    end
  end

  // Per-channel sign extension, load-or-add accumulation and capture selection.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      samp_s[c] = {{DEC_W{data_i[c*IN_W+IN_W-1]}}, data_i[c*IN_W +: IN_W]};
      if (first_s) begin
        nxt_acc_s[c] = samp_s[c];
      end else begin
        nxt_acc_s[c] = acc_r[c] + samp_s[c];
      end
      if (eff_mode_s == MODE_SUM) begin
        cap_in_s[c] = nxt_acc_s[c];
      end else begin
        cap_in_s[c] = samp_s[c];
      end
    end
  end

  // Frame counter, shadow config, accumulators and capture stage.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_r       <= {DEC_W{1'b0}};
      mode_r      <= MODE_PICK;
      dec_m1_r    <= {DEC_W{1'b0}};
      shift_r     <= {SH_W{1'b0}};
      cap_valid_r <= 1'b0;
      cap_sh_r    <= {TSH_W{1'b0}};
      for (int c = 0; c < NCH; c++) begin
        acc_r[c] <= {ACC_W{1'b0}};
        cap_r[c] <= {ACC_W{1'b0}};
      end
    end else if (clr_i) begin
      cnt_r       <= {DEC_W{1'b0}};
      cap_valid_r <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        acc_r[c] <= {ACC_W{1'b0}};
      end
    end else begin
      cap_valid_r <= in_valid_i & last_s;
      if (in_valid_i) begin
        if (first_s) begin
          mode_r   <= eff_mode_s;
          dec_m1_r <= eff_dec_s;
          shift_r  <= eff_shift_s;
        end
        cnt_r <= last_s ? {DEC_W{1'b0}} : cnt_r + DEC_W'(1);
        for (int c = 0; c < NCH; c++) begin
          acc_r[c] <= nxt_acc_s[c];
          if (last_s) begin
            cap_r[c] <= cap_in_s[c];
          end
        end
        if (last_s) begin
          cap_sh_r <= frame_sh_s;
        end
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    rx_round_sat #(
      .IN_W  (ACC_W),
      .OUT_W (OUT_W),
      .SH_W  (TSH_W)
    ) u_round_sat (
      .sample (cap_r[c]),
      .shift  (cap_sh_r),
      .result (res_s[c]),
      .clip   (clip_s[c])
    );
  end

  // Pack the per-channel results into the output bus layout.
  always_comb begin
    data_pack_s = {(NCH*OUT_W){1'b0}};
    for (int c = 0; c < NCH; c++) begin
      data_pack_s[c*OUT_W +: OUT_W] = res_s[c];
    end
  end

  // Output stage: one-cycle strobe, data held between strobes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o <= 1'b0;
      data_o  <= {(NCH*OUT_W){1'b0}};
      sat_o   <= 1'b0;
    end else begin
      valid_o <= cap_valid_r;
      sat_o   <= cap_valid_r & (|clip_s);
      if (cap_valid_r) begin
        data_o <= data_pack_s;
      end
    end
  end

endmodule
